// File: rtl/eth_rx_rmii_if.sv
`timescale 1ns/1ps
// eth_rx_rmii_if -- receive-side output bundle of the RMII receiver.
//   out     : assembled word, first-received dibit in bits [1:0]
//   outclk  : one-cycle strobe, out valid in the same cycle
//   sof     : marks the first word of a frame (with outclk)
//   done    : one-cycle end-of-frame strobe
//   err/len/fcs_ok : frame status, valid while done is high
// master = receiver (drives), slave = consumer.
interface eth_rx_rmii_if #(
  parameter int OUT_WIDTH = 8
);
  logic [OUT_WIDTH-1:0] out;
  logic                 outclk;
  logic                 sof;
  logic                 done;
  logic                 err;
  logic [15:0]          len;
  logic                 fcs_ok;

  modport master (output out, outclk, sof, done, err, len, fcs_ok);
  modport slave  (input  out, outclk, sof, done, err, len, fcs_ok);
endinterface

// File: rtl/eth_rx_rmii.sv
`timescale 1ns/1ps
// eth_rx_rmii -- RMII receiver with PHY reset/strap sequencer.
//   clk       : RMII REF_CLK (50 MHz), only clock
//   rstn      : async active-low reset; release restarts the PHY reset sequence
//   speed_10  : 1 = 10 Mb/s (one dibit per 10 clk), 0 = 100 Mb/s
//   crsdv/rxd/rxerr/intn : PHY pins; carry mode/address straps until the
//                          sequence completes, then released (Z)
//   phy_rstn  : PHY reset, active-low
//   rx        : output word/status bundle (eth_rx_rmii_if.master)
// Optional feature: define ETH_RX_FCS_CHECK_EN to add the CRC-32 FCS check;
// without it fcs_ok is tied to 1.
module eth_rx_rmii #(
  parameter int         OUT_WIDTH       = 8,
  parameter int         RESET_SETUP     = 10,
  parameter int         RESET_HOLD      = 5,
  parameter int         MAX_FRAME_BYTES = 1522,
  parameter logic [2:0] STRAP_MODE      = 3'b011
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         speed_10,
  inout  wire          crsdv,
  inout  wire  [1:0]   rxd,
  inout  wire          rxerr,
  inout  wire          intn,
  output logic         phy_rstn,
  eth_rx_rmii_if.master rx
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_SFD  = 2'd2;
  localparam logic [1:0] ST_RX   = 2'd3;

  localparam int         DPW      = OUT_WIDTH / 2;
  localparam logic [2:0] DPW_LAST = 3'(DPW - 1);
  localparam int         TOTAL    = RESET_SETUP + RESET_HOLD;
  localparam int         SW       = (TOTAL < 1) ? 1 : $clog2(TOTAL + 1);

  // ---------------- PHY reset / strap sequencer ----------------
  logic [SW-1:0] seq_cnt;
  logic          reset_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seq_cnt    <= '0;
      phy_rstn   <= 1'b0;
      reset_done <= 1'b0;
    end else begin
      if (seq_cnt != SW'(TOTAL)) seq_cnt <= seq_cnt + SW'(1);
      phy_rstn   <= (32'(seq_cnt) + 32'd1) >= 32'(RESET_SETUP);
      reset_done <= (32'(seq_cnt) + 32'd1) >= 32'(TOTAL);
    end
  end

  assign crsdv = reset_done ? 1'bz  : STRAP_MODE[2];
  assign rxd   = reset_done ? 2'bzz : STRAP_MODE[1:0];
  assign rxerr = reset_done ? 1'bz  : 1'b0;
  assign intn  = reset_done ? 1'bz  : 1'b1;

  // ---------------- pin capture ----------------
  // crsdv_s2 (two flops) only gates IDLE exit; the rest of the FSM runs on
  // the single-registered samples so data and crsdv stay aligned.
  logic       crsdv_s1, crsdv_s2, crsdv_r, rxerr_r;
  logic [1:0] rxd_r;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crsdv_s1 <= 1'b0;
      crsdv_s2 <= 1'b0;
      crsdv_r  <= 1'b0;
      rxd_r    <= 2'b00;
      rxerr_r  <= 1'b0;
    end else begin
      crsdv_s1 <= crsdv;
      crsdv_s2 <= crsdv_s1;
      crsdv_r  <= crsdv;
      rxd_r    <= rxd;
      rxerr_r  <= rxerr;
    end
  end

  // ---------------- receive FSM ----------------
  logic [1:0]           state;
  logic [3:0]           div_cnt;
  logic                 crsdv_prev;
  logic [2:0]           dib_cnt;
  logic [1:0]           byte_dib;
  logic [15:0]          len_cnt;
  logic [OUT_WIDTH-1:0] sh, sh_nxt, out_q;
  logic                 outclk_q, sof_q, done_q, err_q;
  logic                 first_word, rxerr_seen;
  logic                 tick, dv, start, end_err;

  // In IDLE the divider parks at 4 so detection is checked every clk; the
  // clear on IDLE exit then places later ticks ~6 clk into each 10-clk dibit.
  assign tick  = !speed_10 || (div_cnt == 4'd4);
  // Low half of a toggling crsdv still carries data; two equal lows end it.
  assign dv    = crsdv_r || (crsdv_r != crsdv_prev);
  assign start = (state == ST_IDLE) && tick && reset_done && crsdv_s2;
  assign sh_nxt = OUT_WIDTH'({rxd_r, sh} >> 2);
  assign end_err = rxerr_seen || rxerr_r || (dib_cnt != 3'd0) ||
                   (byte_dib != 2'd0) ||
                   (32'(len_cnt) > 32'(MAX_FRAME_BYTES));

`ifdef ETH_RX_FCS_CHECK_EN
  logic [31:0] crc, crc_nxt, crc_rev;
  logic        fcs_ok_q;

  // Reflected (LSB-first) CRC-32, rxd[0] is the earlier bit of each dibit.
  always_comb begin
    crc_nxt = crc;
    for (int b = 0; b < 2; b++)
      crc_nxt = (crc_nxt >> 1) ^ ({32{crc_nxt[0] ^ rxd_r[b]}} & 32'hEDB88320);
  end

  // Residue is compared in normal bit order.
  always_comb begin
    crc_rev = '0;
    for (int i = 0; i < 32; i++) crc_rev[i] = crc[31-i];
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      div_cnt    <= 4'd0;
      crsdv_prev <= 1'b0;
      dib_cnt    <= 3'd0;
      byte_dib   <= 2'd0;
      len_cnt    <= 16'd0;
      sh         <= '0;
      out_q      <= '0;
      outclk_q   <= 1'b0;
      sof_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      first_word <= 1'b0;
      rxerr_seen <= 1'b0;
`ifdef ETH_RX_FCS_CHECK_EN
      crc        <= 32'hFFFF_FFFF;
      fcs_ok_q   <= 1'b0;
`endif
    end else begin
      outclk_q <= 1'b0;
      sof_q    <= 1'b0;
      done_q   <= 1'b0;

      if (state == ST_IDLE) div_cnt <= start ? 4'd0 : 4'd4;
      else                  div_cnt <= (div_cnt == 4'd9) ? 4'd0 : div_cnt + 4'd1;

      if (state == ST_RX && rxerr_r) rxerr_seen <= 1'b1;

      if (tick) begin
        crsdv_prev <= crsdv_r;
        case (state)
          ST_IDLE: if (start) begin
            state      <= ST_PRE;
            len_cnt    <= 16'd0;
            dib_cnt    <= 3'd0;
            byte_dib   <= 2'd0;
            rxerr_seen <= 1'b0;
            first_word <= 1'b1;
`ifdef ETH_RX_FCS_CHECK_EN
            crc        <= 32'hFFFF_FFFF;
`endif
          end
          ST_PRE: begin
            if (!crsdv_r)             state <= ST_IDLE;
            else if (rxd_r == 2'b01)  state <= ST_SFD;
          end
          ST_SFD: begin
            if (!crsdv_r)             state <= ST_IDLE;
            else if (rxd_r == 2'b11)  state <= ST_RX;
            else if (rxd_r != 2'b01)  state <= ST_PRE;
          end
          ST_RX: begin
            if (dv) begin
              sh       <= sh_nxt;
              byte_dib <= byte_dib + 2'd1;
              if (byte_dib == 2'd3 && len_cnt != 16'hFFFF) len_cnt <= len_cnt + 16'd1;
              if (dib_cnt == DPW_LAST) begin
                out_q      <= sh_nxt;
                outclk_q   <= 1'b1;
                sof_q      <= first_word;
                first_word <= 1'b0;
                dib_cnt    <= 3'd0;
              end else begin
                dib_cnt <= dib_cnt + 3'd1;
              end
`ifdef ETH_RX_FCS_CHECK_EN
              crc <= crc_nxt;
`endif
            end else begin
              done_q <= 1'b1;
              err_q  <= end_err;
              state  <= ST_IDLE;
`ifdef ETH_RX_FCS_CHECK_EN
              fcs_ok_q <= (crc_rev == 32'hC704DD7B);
`endif
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx.out    = out_q;
  assign rx.outclk = outclk_q;
  assign rx.sof    = sof_q;
  assign rx.done   = done_q;
  assign rx.err    = err_q;
  assign rx.len    = len_cnt;
`ifdef ETH_RX_FCS_CHECK_EN
  assign rx.fcs_ok = fcs_ok_q;
`else
  assign rx.fcs_ok = 1'b1;
`endif

endmodule
